// File: rtl/projectile_engine_if.sv
// Bundles the player-side launch controls and renderer-side projectile state for projectile_engine.
// master drives requests and hits; slave is the engine itself.
interface projectile_engine_if #(
    parameter int NUM_PROJ = 3,
    parameter int COORD_W  = 6,
    parameter int CNT_W    = 25
);
    logic                        i_launch1;
    logic                        i_launch2;
    logic [1:0]                  i_dir1;
    logic [1:0]                  i_dir2;
    logic [COORD_W-1:0]          i_head_x1;
    logic [COORD_W-1:0]          i_head_y1;
    logic [COORD_W-1:0]          i_head_x2;
    logic [COORD_W-1:0]          i_head_y2;
    logic [CNT_W-1:0]            i_speed;
    logic [NUM_PROJ-1:0]         i_hit;
    logic [NUM_PROJ*COORD_W-1:0] o_proj_x;
    logic [NUM_PROJ*COORD_W-1:0] o_proj_y;
    logic [NUM_PROJ-1:0]         o_alive;
    logic                        o_owner;
    logic                        o_busy;
    logic                        o_done;

    modport master (
        output i_launch1, i_launch2, i_dir1, i_dir2,
               i_head_x1, i_head_y1, i_head_x2, i_head_y2, i_speed, i_hit,
        input  o_proj_x, o_proj_y, o_alive, o_owner, o_busy, o_done
    );

    modport slave (
        input  i_launch1, i_launch2, i_dir1, i_dir2,
               i_head_x1, i_head_y1, i_head_x2, i_head_y2, i_speed, i_hit,
        output o_proj_x, o_proj_y, o_alive, o_owner, o_busy, o_done
    );
endinterface

// File: rtl/projectile_engine.sv
// Projectile launcher/mover: spawns a fan of up to NUM_PROJ projectiles around a player's head and steps them.
// Spawn is visible one cycle after launch; no backpressure, launches are ignored outside IDLE.
module projectile_engine #(
    parameter int NUM_PROJ = 3,
    parameter int COORD_W  = 6,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int SPREAD   = 2,
    parameter int CNT_W    = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    projectile_engine_if.slave  pif
);
    localparam logic [1:0] D_UP = 2'd0;
    localparam logic [1:0] D_DN = 2'd1;
    localparam logic [1:0] D_LT = 2'd2;
    localparam logic [1:0] D_RT = 2'd3;

    localparam logic [COORD_W-1:0]        GW   = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0]        GH   = COORD_W'(GRID_H);
    localparam logic [COORD_W-1:0]        XMAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0]        YMAX = COORD_W'(GRID_H - 1);
    localparam logic signed [COORD_W:0]   SP   = (COORD_W+1)'(SPREAD);

    typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  px_q [NUM_PROJ];
    logic [COORD_W-1:0]  px_d [NUM_PROJ];
    logic [COORD_W-1:0]  py_q [NUM_PROJ];
    logic [COORD_W-1:0]  py_d [NUM_PROJ];
    logic [1:0]          dir_q [NUM_PROJ];
    logic [1:0]          dir_d [NUM_PROJ];
    logic [NUM_PROJ-1:0] alive_q, alive_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                     tick;
    logic [1:0]               hd, sd;
    logic [COORD_W-1:0]       hx, hy;
    logic signed [COORD_W:0]  sx, sy;

    function automatic logic [1:0] left_of(input logic [1:0] h);
        case (h)
            D_UP:    return D_LT;
            D_DN:    return D_RT;
            D_LT:    return D_DN;
            default: return D_UP;
        endcase
    endfunction

    // Opposite direction is the low bit flipped in this encoding.
    function automatic logic [1:0] slot_dir(input logic [1:0] h, input int k);
        case (k)
            0:       return h;
            1:       return left_of(h);
            2:       return left_of(h) ^ 2'd1;
            default: return h ^ 2'd1;
        endcase
    endfunction

    function automatic logic in_range(input logic signed [COORD_W:0] v,
                                      input logic [COORD_W-1:0] lim);
        return !v[COORD_W] && (v[COORD_W-1:0] < lim);
    endfunction

    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < NUM_PROJ; k++) begin
            px_d[k]  = px_q[k];
            py_d[k]  = py_q[k];
            dir_d[k] = dir_q[k];
        end
        tick = 1'b0;
        hd   = '0;
        hx   = '0;
        hy   = '0;
        sd   = '0;
        sx   = '0;
        sy   = '0;

        case (state_q)
            IDLE: begin
                if (pif.i_launch1 || pif.i_launch2) begin
                    owner_d = ~pif.i_launch1;
                    hd = pif.i_launch1 ? pif.i_dir1    : pif.i_dir2;
                    hx = pif.i_launch1 ? pif.i_head_x1 : pif.i_head_x2;
                    hy = pif.i_launch1 ? pif.i_head_y1 : pif.i_head_y2;
                    for (int k = 0; k < NUM_PROJ; k++) begin
                        sd = slot_dir(hd, k);
                        sx = {1'b0, hx};
                        sy = {1'b0, hy};
                        case (sd)
                            D_UP:    sy = sy - SP;
                            D_DN:    sy = sy + SP;
                            D_LT:    sx = sx - SP;
                            default: sx = sx + SP;
                        endcase
                        dir_d[k] = sd;
                        if (in_range(sx, GW) && in_range(sy, GH)) begin
                            alive_d[k] = 1'b1;
                            px_d[k]    = sx[COORD_W-1:0];
                            py_d[k]    = sy[COORD_W-1:0];
                        end else begin
                            alive_d[k] = 1'b0;
                            px_d[k]    = '0;
                            py_d[k]    = '0;
                        end
                    end
                    cnt_d   = '0;
                    state_d = FLY;
                end
            end
            FLY: begin
                tick  = (cnt_q == pif.i_speed);
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                // A hit wins over a step; stepping off the edge kills but keeps the last legal cell.
                for (int k = 0; k < NUM_PROJ; k++) begin
                    if (alive_q[k]) begin
                        if (pif.i_hit[k]) begin
                            alive_d[k] = 1'b0;
                        end else if (tick) begin
                            case (dir_q[k])
                                D_UP: if (py_q[k] == '0)  alive_d[k] = 1'b0;
                                      else                py_d[k] = py_q[k] - COORD_W'(1);
                                D_DN: if (py_q[k] == YMAX) alive_d[k] = 1'b0;
                                      else                py_d[k] = py_q[k] + COORD_W'(1);
                                D_LT: if (px_q[k] == '0)  alive_d[k] = 1'b0;
                                      else                px_d[k] = px_q[k] - COORD_W'(1);
                                default: if (px_q[k] == XMAX) alive_d[k] = 1'b0;
                                         else                 px_d[k] = px_q[k] + COORD_W'(1);
                            endcase
                        end
                    end
                end
                if (alive_d == '0) state_d = DONE;
            end
            DONE: begin
                alive_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_PROJ; k++) begin
                px_q[k]  <= '0;
                py_q[k]  <= '0;
                dir_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < NUM_PROJ; k++) begin
                px_q[k]  <= px_d[k];
                py_q[k]  <= py_d[k];
                dir_q[k] <= dir_d[k];
            end
        end
    end

    always_comb begin
        pif.o_proj_x = '0;
        pif.o_proj_y = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            pif.o_proj_x[k*COORD_W +: COORD_W] = px_q[k];
            pif.o_proj_y[k*COORD_W +: COORD_W] = py_q[k];
        end
    end

    assign pif.o_alive = alive_q;
    assign pif.o_owner = owner_q;
    assign pif.o_busy  = (state_q == FLY);
    assign pif.o_done  = (state_q == DONE);

    logic unused_ok;
    assign unused_ok = &{1'b0, GH};
endmodule

// File: doc/projectile_engine.md
Name: projectile_engine

Overview:
- Parametrised projectile ("boom") launcher/mover for the two-player snake game.
- On a launch request from either player, it spawns up to NUM_PROJ projectiles in a fan around that player's head.
- Each projectile then steps one cell per speed tick in its own direction. It dies on leaving the grid or on an external hit.
- Sits between the player control logic and the renderer/collision checker. It owns all projectile coordinates and liveness.

Parameters:
- NUM_PROJ, 3, projectile count, legal 1..4; projectile k uses direction slot k: 0=forward, 1=left of heading, 2=right of heading, 3=backward.
- COORD_W, 6, coordinate width.
- GRID_W, 40, playfield columns; legal x is 0..GRID_W-1.
- GRID_H, 30, playfield rows; legal y is 0..GRID_H-1.
- SPREAD, 2, spawn distance from the head in cells.
- CNT_W, 25, width of the speed counter and i_speed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_launch1  in  1  player1 launch request (level, sampled in IDLE)
- i_launch2  in  1  player2 launch request
- i_dir1  in  2  player1 heading: 0=UP(y-1), 1=DOWN(y+1), 2=LEFT(x-1), 3=RIGHT(x+1)
- i_dir2  in  2  player2 heading
- i_head_x1, i_head_y1  in  COORD_W each  player1 head position
- i_head_x2, i_head_y2  in  COORD_W each  player2 head position
- i_speed  in  CNT_W  clocks per step minus 1
- i_hit  in  NUM_PROJ  per-projectile kill strobe from the collision checker
- o_proj_x  out  NUM_PROJ*COORD_W  packed x; projectile k is at [k*COORD_W +: COORD_W]
- o_proj_y  out  NUM_PROJ*COORD_W  packed y
- o_alive  out  NUM_PROJ  projectile valid/visible
- o_owner  out  1  0=player1, 1=player2; valid while o_busy
- o_busy  out  1  volley in flight
- o_done  out  1  one-cycle pulse when a volley ends

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; speed counter 0.
- States: IDLE, FLY, DONE.
- IDLE:
  - o_busy=0, o_alive=0, coordinates hold their last values.
  - If i_launch1=1: owner=0, latch i_dir1 and head1. Player1 wins if both requests are asserted together.
  - Else if i_launch2=1: owner=1, latch i_dir2 and head2.
  - On launch, go to FLY next cycle with spawn positions registered and the counter cleared.
- Rotation:
  - left-of: UP→LEFT, DOWN→RIGHT, LEFT→DOWN, RIGHT→UP.
  - right-of is the opposite of left-of; backward is the opposite of the heading.
- Spawn arithmetic:
  - Each spawn coordinate is head ± SPREAD along the projectile's own direction, computed signed at COORD_W+1 bits.
  - If a spawn coordinate is <0, ≥GRID_W (x) or ≥GRID_H (y), that projectile spawns with alive=0 and coordinates 0.
  - Otherwise alive=1.
- FLY:
  - o_busy=1; the counter increments every cycle.
  - When counter==i_speed: counter→0 and every alive projectile steps 1 cell in its direction. i_speed=0 means a step every cycle.
  - Out-of-grid step: a step that would leave the grid (x=0 moving LEFT, x=GRID_W-1 moving RIGHT, same for y) clears alive and holds the position. Wrap-around never occurs.
  - Hit: i_hit[k]=1 clears alive[k] that cycle, with priority over a simultaneous step. Hits on dead projectiles are ignored.
  - If all alive bits are 0 (after the current cycle's updates, or immediately after spawn), go to DONE.
  - Launch requests are ignored while FLY and DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0, alive=0; then IDLE. A launch still held is taken on the first IDLE cycle, giving a minimum of 1 idle cycle between volleys.
- Heading and head inputs are sampled only at launch; later changes do not affect a volley in flight.
- A change of i_speed mid-flight takes effect at the next comparison. If the counter is already above the new i_speed, it runs until wrap (documented behaviour, not an error).
- Reset mid-flight returns to IDLE immediately with all outputs 0; no o_done is emitted.

Test Plan:
- Reset, then player1 launch with dir=UP, head (10,10), NUM_PROJ=3, i_speed=0:
  - next cycle proj0=(10,8), proj1=(8,10), proj2=(12,10), alive=3'b111, owner=0, busy=1.
  - each following cycle: proj0 y-1, proj1 x-1, proj2 x+1.
- Same launch with i_speed=4: positions change exactly every 5 clocks.
  - proj1 reaches x=0 at step 8; on step 9 alive[1] clears and position holds (0,10).
  - o_done pulses once after all three die, then busy=0.
- Player2 dir=RIGHT, head (1,0):
  - proj1 (left-of RIGHT = UP) spawns at y=-2 → alive[1]=0 from the first FLY cycle.
  - proj0=(3,0), proj2=(1,2) alive; owner=1.
- i_launch1 and i_launch2 asserted in the same cycle → owner=0. A re-pulse of i_launch2 during FLY is ignored and no respawn occurs.
- During FLY, i_hit=3'b010 on a step cycle → alive=3'b101 and proj1 does not move.
  - A following i_hit=3'b101 → DONE, o_done=1 for 1 cycle, then IDLE.
- rst_n low mid-flight → o_alive, o_busy and coordinates are 0 immediately; no o_done; a launch after release works normally.
